// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// opcode/funct constants, ALU and next-PC select codes, instruction class vector.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b110;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_J26    = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  // One-hot instruction class; all-zero means the encoding is unsupported.
  typedef struct packed {
    logic is_addu;
    logic is_subu;
    logic is_xor;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;
  } instr_cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller-to-datapath bundle: IR/flag/ack inputs, enables, selects, counters.
// master = the sequencer, slave = the datapath side.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ack;

  logic        ir_we;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        regw;
  logic        regdst;
  logic        jal_dst;
  logic        memtoreg;
  logic        alusrc;
  logic        signop;
  logic        zeroop;
  logic [2:0]  alu_op;
  logic        mem_req;
  logic        mem_we;
  logic        illegal;
  logic [31:0] retired;
  logic [31:0] cycles;

  modport master (
    input  instr, zero, mem_ack,
    output ir_we, pc_we, npc_sel, regw, regdst, jal_dst, memtoreg, alusrc,
           signop, zeroop, alu_op, mem_req, mem_we, illegal, retired, cycles
  );

  modport slave (
    output instr, zero, mem_ack,
    input  ir_we, pc_we, npc_sel, regw, regdst, jal_dst, memtoreg, alusrc,
           signop, zeroop, alu_op, mem_req, mem_we, illegal, retired, cycles
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Purely combinational instruction classifier: opcode/funct to a one-hot
// class vector plus an illegal flag.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output instr_cls_t  cls_o,
  output logic        illegal_o
);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    // NOTE: default every output first so no path through the case infers a latch.
    cls_o = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls_o.is_addu = 1'b1;
          FN_SUBU: cls_o.is_subu = 1'b1;
          FN_XOR:  cls_o.is_xor  = 1'b1;
          FN_JR:   cls_o.is_jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls_o.is_ori = 1'b1;
      OP_LUI:  cls_o.is_lui = 1'b1;
      OP_LW:   cls_o.is_lw  = 1'b1;
      OP_SW:   cls_o.is_sw  = 1'b1;
      OP_BEQ:  cls_o.is_beq = 1'b1;
      OP_J:    cls_o.is_j   = 1'b1;
      OP_JAL:  cls_o.is_jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = (cls_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS subset.
// Define MC_CTRL_PERF_EN to build the retired/cycles performance counters.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);
  state_t     state_q;
  state_t     state_out;
  instr_cls_t cls;
  logic       dec_illegal;
  logic       is_rtype_alu;

  mc_decode u_decode (
    .instr_i   (bus.instr),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  assign is_rtype_alu = cls.is_addu | cls.is_subu | cls.is_xor;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: state_q <= dec_illegal ? FETCH : EXEC;
        EXEC: begin
          if (cls.is_beq | cls.is_j | cls.is_jr) state_q <= FETCH;
          else if (cls.is_lw | cls.is_sw)        state_q <= MEM;
          else                                   state_q <= WB;
        end
        MEM: begin
          if (bus.mem_ack) state_q <= cls.is_lw ? WB : FETCH;
        end
        WB:      state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  // While reset is held, present FETCH outputs so an aborted instruction
  // never issues a register write or PC update.
  assign state_out = reset ? FETCH : state_q;

  always_comb begin
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.npc_sel  = NPC_PC4;
    bus.regw     = 1'b0;
    bus.regdst   = 1'b0;
    bus.jal_dst  = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrc   = 1'b0;
    bus.signop   = 1'b0;
    bus.zeroop   = 1'b0;
    bus.alu_op   = ALU_NOP;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.illegal  = 1'b0;

    // Extender selects follow the instruction from DECODE until it retires.
    if (state_out != FETCH) begin
      bus.signop = cls.is_lw | cls.is_sw | cls.is_beq;
      bus.zeroop = cls.is_ori | cls.is_lui;
    end

    case (state_out)
      FETCH: bus.ir_we = 1'b1;

      DECODE: begin
        if (dec_illegal) begin
          bus.illegal = 1'b1;
          bus.pc_we   = 1'b1;
        end
      end

      EXEC: begin
        bus.alusrc = cls.is_ori | cls.is_lui | cls.is_lw | cls.is_sw;
        if (cls.is_addu | cls.is_lw | cls.is_sw) bus.alu_op = ALU_ADD;
        else if (cls.is_subu | cls.is_beq)       bus.alu_op = ALU_SUB;
        else if (cls.is_ori)                     bus.alu_op = ALU_OR;
        else if (cls.is_xor)                     bus.alu_op = ALU_XOR;
        else if (cls.is_lui)                     bus.alu_op = ALU_LUI;

        if (cls.is_beq) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = bus.zero ? NPC_BRANCH : NPC_PC4;
        end else if (cls.is_j) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = NPC_J26;
        end else if (cls.is_jr) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = NPC_RS;
        end
      end

      MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = cls.is_sw;
        bus.pc_we   = cls.is_sw & bus.mem_ack;
      end

      WB: begin
        bus.regw     = 1'b1;
        bus.pc_we    = 1'b1;
        bus.npc_sel  = cls.is_jal ? NPC_J26 : NPC_PC4;
        bus.regdst   = is_rtype_alu;
        bus.memtoreg = cls.is_lw;
        bus.jal_dst  = cls.is_jal;
      end

      default: ;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] retired_q, retired_d;

  assign cycles_d  = cycles_q + 32'd1;
  assign retired_d = retired_q + {31'd0, bus.pc_we};

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
    end
  end

  assign bus.cycles  = cycles_q;
  assign bus.retired = retired_q;
`else
  assign bus.cycles  = '0;
  assign bus.retired = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instruction sequences push per-cycle
// expected control words; a negedge monitor pops and compares them.
module tb_mc_ctrl;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       regw;
    logic       regdst;
    logic       jal_dst;
    logic       memtoreg;
    logic       alusrc;
    logic       signop;
    logic       zeroop;
    logic [2:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       name;
    ctl_t        ctl;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  localparam ctl_t F = ctl_t'{ir_we: 1'b1, default: '0};
  localparam ctl_t Z = ctl_t'{default: '0};

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push this cycle's expectation, advance one clock, update the counter model.
  task automatic step(input string name, input ctl_t c);
    exp_t e;
    e.name = name;
    e.ctl  = c;
    e.cyc  = m_cyc;
    e.ret  = m_ret;
    sb_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_cyc = '0;
      m_ret = '0;
    end else begin
`ifdef MC_CTRL_PERF_EN
      m_cyc = m_cyc + 32'd1;
      m_ret = m_ret + {31'd0, c.pc_we};
`endif
    end
    #1;
  endtask

  exp_t mon_e;
  ctl_t mon_act;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {bus.ir_we, bus.pc_we, bus.npc_sel, bus.regw, bus.regdst,
                 bus.jal_dst, bus.memtoreg, bus.alusrc, bus.signop, bus.zeroop,
                 bus.alu_op, bus.mem_req, bus.mem_we, bus.illegal};
      check({mon_e.name, ".ctl"}, {15'd0, mon_act}, {15'd0, mon_e.ctl});
      check({mon_e.name, ".cycles"}, bus.cycles, mon_e.cyc);
      check({mon_e.name, ".retired"}, bus.retired, mon_e.ret);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.instr   = '0;
    bus.zero    = 1'b0;
    bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    step("rst0", F);
    step("rst1", F);
    reset = 1'b0;

    // ori $1,$0,0x00ff
    bus.instr = 32'h340100ff;
    step("ori.F", F);
    step("ori.D", ctl_t'{zeroop: 1'b1, default: '0});
    step("ori.E", ctl_t'{zeroop: 1'b1, alusrc: 1'b1, alu_op: 3'b001, default: '0});
    step("ori.W", ctl_t'{zeroop: 1'b1, regw: 1'b1, pc_we: 1'b1, default: '0});

    // lui $1,0x1234
    bus.instr = 32'h3c011234;
    step("lui.F", F);
    step("lui.D", ctl_t'{zeroop: 1'b1, default: '0});
    step("lui.E", ctl_t'{zeroop: 1'b1, alusrc: 1'b1, alu_op: 3'b110, default: '0});
    step("lui.W", ctl_t'{zeroop: 1'b1, regw: 1'b1, pc_we: 1'b1, default: '0});

    // addu / subu / xor $3,$1,$2
    bus.instr = 32'h00221821;
    step("addu.F", F);
    step("addu.D", Z);
    step("addu.E", ctl_t'{alu_op: 3'b010, default: '0});
    step("addu.W", ctl_t'{regw: 1'b1, regdst: 1'b1, pc_we: 1'b1, default: '0});
    bus.instr = 32'h00221823;
    step("subu.F", F);
    step("subu.D", Z);
    step("subu.E", ctl_t'{alu_op: 3'b011, default: '0});
    step("subu.W", ctl_t'{regw: 1'b1, regdst: 1'b1, pc_we: 1'b1, default: '0});
    bus.instr = 32'h00221826;
    step("xor.F", F);
    step("xor.D", Z);
    step("xor.E", ctl_t'{alu_op: 3'b100, default: '0});
    step("xor.W", ctl_t'{regw: 1'b1, regdst: 1'b1, pc_we: 1'b1, default: '0});

    // beq taken, then not taken
    bus.instr = 32'h10210004;
    step("beq1.F", F);
    step("beq1.D", ctl_t'{signop: 1'b1, default: '0});
    bus.zero = 1'b1;
    step("beq1.E", ctl_t'{signop: 1'b1, alu_op: 3'b011, pc_we: 1'b1, npc_sel: 2'b01, default: '0});
    step("beq2.F", F);
    bus.zero = 1'b0;
    step("beq2.D", ctl_t'{signop: 1'b1, default: '0});
    step("beq2.E", ctl_t'{signop: 1'b1, alu_op: 3'b011, pc_we: 1'b1, npc_sel: 2'b00, default: '0});

    // j, jr $31
    bus.instr = 32'h08000010;
    step("j.F", F);
    step("j.D", Z);
    step("j.E", ctl_t'{pc_we: 1'b1, npc_sel: 2'b10, default: '0});
    bus.instr = 32'h03e00008;
    step("jr.F", F);
    step("jr.D", Z);
    step("jr.E", ctl_t'{pc_we: 1'b1, npc_sel: 2'b11, default: '0});

    // lw with three wait cycles; an early ack in EXEC must be ignored
    bus.instr = 32'h8c220008;
    step("lw.F", F);
    step("lw.D", ctl_t'{signop: 1'b1, default: '0});
    bus.mem_ack = 1'b1;
    step("lw.E", ctl_t'{signop: 1'b1, alusrc: 1'b1, alu_op: 3'b010, default: '0});
    bus.mem_ack = 1'b0;
    step("lw.M0", ctl_t'{signop: 1'b1, mem_req: 1'b1, default: '0});
    step("lw.M1", ctl_t'{signop: 1'b1, mem_req: 1'b1, default: '0});
    step("lw.M2", ctl_t'{signop: 1'b1, mem_req: 1'b1, default: '0});
    bus.mem_ack = 1'b1;
    step("lw.M3", ctl_t'{signop: 1'b1, mem_req: 1'b1, default: '0});
    bus.mem_ack = 1'b0;
    step("lw.W", ctl_t'{signop: 1'b1, regw: 1'b1, memtoreg: 1'b1, pc_we: 1'b1, default: '0});

    // sw with zero-wait memory
    bus.instr = 32'hac220008;
    step("sw.F", F);
    step("sw.D", ctl_t'{signop: 1'b1, default: '0});
    step("sw.E", ctl_t'{signop: 1'b1, alusrc: 1'b1, alu_op: 3'b010, default: '0});
    bus.mem_ack = 1'b1;
    step("sw.M0", ctl_t'{signop: 1'b1, mem_req: 1'b1, mem_we: 1'b1, pc_we: 1'b1, default: '0});
    bus.mem_ack = 1'b0;

    // jal
    bus.instr = 32'h0c000010;
    step("jal.F", F);
    step("jal.D", Z);
    step("jal.E", Z);
    step("jal.W", ctl_t'{regw: 1'b1, jal_dst: 1'b1, pc_we: 1'b1, npc_sel: 2'b10, default: '0});

    // illegal opcode 111111, then illegal R-type funct
    bus.instr = 32'hfc000000;
    step("ill1.F", F);
    step("ill1.D", ctl_t'{illegal: 1'b1, pc_we: 1'b1, default: '0});
    bus.instr = 32'h0000003f;
    step("ill2.F", F);
    step("ill2.D", ctl_t'{illegal: 1'b1, pc_we: 1'b1, default: '0});

    // reset during a lw memory wait aborts without regw/pc_we
    bus.instr = 32'h8c220008;
    step("abort.F", F);
    step("abort.D", ctl_t'{signop: 1'b1, default: '0});
    step("abort.E", ctl_t'{signop: 1'b1, alusrc: 1'b1, alu_op: 3'b010, default: '0});
    step("abort.M0", ctl_t'{signop: 1'b1, mem_req: 1'b1, default: '0});
    reset = 1'b1;
    step("abort.rst", F);
    reset = 1'b0;
    step("abort.after", F);
    step("abort.D2", ctl_t'{signop: 1'b1, default: '0});
    step("abort.E2", ctl_t'{signop: 1'b1, alusrc: 1'b1, alu_op: 3'b010, default: '0});
    bus.mem_ack = 1'b1;
    step("abort.M2", ctl_t'{signop: 1'b1, mem_req: 1'b1, default: '0});
    bus.mem_ack = 1'b0;
    step("abort.W2", ctl_t'{signop: 1'b1, regw: 1'b1, memtoreg: 1'b1, pc_we: 1'b1, default: '0});
    step("end.F", F);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS datapath: it walks each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath enable and mux select for the supported subset: addu, subu, xor, jr, ori, lui, lw, sw, beq, j and jal. It sits between the instruction register and the shared ALU, register file and data memory, which are each used once per instruction step. Data-memory accesses use a req/ack handshake, so variable-latency memory stalls the sequence.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces state to FETCH
- instr  in  32  IR contents; stable from DECODE to end of instruction
- zero  in  1  ALU equal flag, sampled in EXEC for beq
- mem_ack  in  1  data memory done; valid only while mem_req=1
- ir_we  out  1  load IR from instruction memory
- pc_we  out  1  update PC (exactly one pulse per instruction)
- npc_sel  out  2  00 pc+4, 01 branch target, 10 j26 target, 11 rs (jr)
- regw / regdst / jal_dst  out  1 each  GRF write, rd-vs-rt select, force $31
- memtoreg  out  1  GRF data from memory
- alusrc  out  1  ALU B = extended immediate
- signop / zeroop  out  1 each  sign- / zero-extend immediate
- alu_op  out  3  010 add, 011 sub, 001 or, 100 xor, 110 lui
- mem_req / mem_we  out  1 each  data-memory request, write qualifier
- illegal  out  1  unsupported encoding seen in DECODE
- retired / cycles  out  32 each  perf counters (see Configuration)

## Operation
- Decoding: opcode `instr[31:26]`, funct `instr[5:0]`. R-type (000000) covers addu 100001, subu 100011, xor 100110 and jr 001000. I-type covers ori 001101, lui 001111, lw 100011, sw 101011 and beq 000100. J-type covers j 000010 and jal 000011.
- FETCH: ir_we=1. Always goes to DECODE next.
- DECODE: only extender selects are driven. A legal instruction goes to EXEC. An illegal one raises illegal, pulses pc_we with npc_sel=00, and returns to FETCH.
- EXEC: alu_op and alusrc are driven.
  - beq: pc_we=1, npc_sel = zero ? 01 : 00. Goes to FETCH.
  - j: pc_we=1, npc_sel=10. Goes to FETCH. jr: pc_we=1, npc_sel=11. Goes to FETCH.
  - lw/sw: go to MEM. All other instructions go to WB.
- MEM: mem_req=1, mem_we=sw. The FSM stays in MEM until mem_ack=1.
  - On ack, lw goes to WB.
  - On ack, sw pulses pc_we (npc_sel=00) and goes to FETCH.
- WB: regw=1 and pc_we=1. npc_sel=10 for jal, otherwise 00. regdst is set for R-type. memtoreg is set for lw. jal_dst is set for jal, which writes pc+4. Goes to FETCH.
- Outputs are Moore-style: a function of the current state plus instr, except that zero and mem_ack combinationally qualify pc_we and npc_sel.
- Reset values (state FETCH): ir_we=1. Every other control output is 0. Counters are 0.

## Timing
- Cycles per instruction: beq/j/jr take 3; addu/subu/xor/ori/lui/jal take 4; sw takes 4+W; lw takes 5+W. W is the number of cycles spent with mem_ack=0 in MEM.
- A zero-wait memory (ack in the first MEM cycle) gives W=0.
- mem_ack outside MEM is ignored.
- mem_req stays high continuously until the ack cycle, including that cycle, and drops the next cycle.
- Reset asserted mid-instruction (including mid-MEM-wait) returns to FETCH on the next edge. No regw or pc_we is issued for the aborted instruction.

## Configuration
- MC_CTRL_PERF_EN defined:
  - cycles increments every non-reset cycle.
  - retired increments on every pc_we cycle, including illegal instructions.
  - Both counters wrap at 2^32 and are cleared by reset.
- MC_CTRL_PERF_EN undefined: both ports remain and are tied to 0, and no counter flops are built.

## Structure
- Package mc_ctrl_pkg holds the state enum (FETCH, DECODE, EXEC, MEM, WB), the opcode and funct constants, the alu_op codes and the npc_sel codes.
- Sub-module mc_decode is purely combinational: instr to a one-hot instruction class plus illegal. The FSM consumes only that class vector.

## Test plan
- Reset, then ori $1,$0,0x00ff → ir_we at cycle 0; alu_op=001 and zeroop=1 in EXEC; regw=1 and pc_we=1 at cycle 3; retired=1 with PERF_EN.
- beq with zero=1, then zero=0 → pc_we at cycle 2 with npc_sel=01, then 00; regw never asserted.
- lw with mem_ack delayed 3 cycles → mem_req high for 4 cycles; regw and memtoreg at cycle 7; mem_we=0.
- sw with mem_ack in the first MEM cycle → mem_we=1 for one cycle; pc_we at cycle 3; regw=0.
- jal → WB cycle has regw=1, jal_dst=1, npc_sel=10; total 4 cycles.
- Opcode 111111 → illegal=1 and pc_we with npc_sel=00 at cycle 1. Separately, reset raised during a lw MEM wait → state FETCH next edge, no regw.
